// File: rtl/qsfa_chan_sched_pkg.sv
// Shared types and constants for the QSFA per-channel scheduler.
package qsfa_chan_sched_pkg;

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StIdle = 3'd1,
        StRd   = 3'd2,
        StLoad = 3'd3,
        StCalc = 3'd4,
        StWb   = 3'd5
    } sched_state_e;

    localparam logic [12:0] QSFA_YU_RST      = 13'd544;
    localparam logic [18:0] QSFA_YL_RST      = 19'd34816;
    // RD + LOAD + WB cycles spent on each channel besides CALC.
    localparam int unsigned QSFA_CH_OVERHEAD = 3;
    localparam int unsigned QSFA_CALC_CNT_W  = 4;

endpackage

// File: rtl/qsfa_chan_sched_if.sv
// Scheduler <-> state RAM / datapath signal bundle.
// Overrun counter signals exist only with QSFA_SCHED_OVERRUN_CNT_EN defined.
interface qsfa_chan_sched_if #(
    parameter int unsigned CH_W = 5
);
    logic            frame_sync;
    logic [CH_W-1:0] ch_addr;
    logic            mem_rd_en;
    logic            ld_strb;
    logic            mem_wr_en;
    logic            wr_init;
    logic            dly_strb;
    logic            busy;
    logic            init_done;
    logic            frame_done;
    logic            overrun;
`ifdef QSFA_SCHED_OVERRUN_CNT_EN
    logic            ovr_clr;
    logic [7:0]      ovr_cnt;

    modport master (
        input  frame_sync, ovr_clr,
        output ch_addr, mem_rd_en, ld_strb, mem_wr_en, wr_init, dly_strb,
               busy, init_done, frame_done, overrun, ovr_cnt
    );
    modport slave (
        output frame_sync, ovr_clr,
        input  ch_addr, mem_rd_en, ld_strb, mem_wr_en, wr_init, dly_strb,
               busy, init_done, frame_done, overrun, ovr_cnt
    );
`else
    modport master (
        input  frame_sync,
        output ch_addr, mem_rd_en, ld_strb, mem_wr_en, wr_init, dly_strb,
               busy, init_done, frame_done, overrun
    );
    modport slave (
        output frame_sync,
        input  ch_addr, mem_rd_en, ld_strb, mem_wr_en, wr_init, dly_strb,
               busy, init_done, frame_done, overrun
    );
`endif
endinterface

// File: rtl/qsfa_sched_calc_cnt.sv
// Loadable down-counter timing the CALC phase; tc flags a count of zero.
module qsfa_sched_calc_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == '0);
endmodule

// File: rtl/qsfa_chan_sched.sv
// Time-shares one QSFA adaptation datapath across NUM_CH channels per frame_sync.
// Optional saturating overrun counter: define QSFA_SCHED_OVERRUN_CNT_EN.
module qsfa_chan_sched
    import qsfa_chan_sched_pkg::*;
#(
    parameter int unsigned NUM_CH      = 32,
    parameter int unsigned CH_W        = 5,
    parameter int unsigned CALC_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    qsfa_chan_sched_if.master bus
);
    localparam logic [CH_W-1:0]            LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [QSFA_CALC_CNT_W-1:0] CALC_LD = QSFA_CALC_CNT_W'(CALC_CYCLES - 1);

    sched_state_e state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic mem_rd_en_q, ld_strb_q, mem_wr_en_q, wr_init_q, dly_strb_q;
    logic busy_q, init_done_q, frame_done_q, overrun_q;
    logic init_done_d;
    logic cnt_load, cnt_dec, cnt_tc;
    logic [QSFA_CALC_CNT_W-1:0] cnt_val;

    qsfa_sched_calc_cnt #(
        .W(QSFA_CALC_CNT_W)
    ) u_calc_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(CALC_LD),
        .cnt     (cnt_val),
        .tc      (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        init_done_d = init_done_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state_q)
            // First INIT cycle after reset only arms the write; mem_wr_en_q marks a live write.
            StInit: begin
                if (mem_wr_en_q && ch_q == LAST_CH) begin
                    state_d     = StIdle;
                    ch_d        = '0;
                    init_done_d = 1'b1;
                end else if (mem_wr_en_q) begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StIdle: begin
                if (bus.frame_sync) begin
                    state_d = StRd;
                    ch_d    = '0;
                end
            end
            StRd:   state_d = StLoad;
            StLoad: begin
                state_d  = StCalc;
                cnt_load = 1'b1;
            end
            StCalc: begin
                if (cnt_tc) begin
                    state_d = StWb;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StWb: begin
                if (ch_q == LAST_CH) begin
                    state_d = StIdle;
                    ch_d    = '0;
                end else begin
                    state_d = StRd;
                    ch_d    = ch_q + 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StInit;
            ch_q         <= '0;
            mem_rd_en_q  <= 1'b0;
            ld_strb_q    <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            wr_init_q    <= 1'b0;
            dly_strb_q   <= 1'b0;
            busy_q       <= 1'b1;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            mem_rd_en_q  <= (state_d == StRd);
            ld_strb_q    <= (state_d == StLoad);
            mem_wr_en_q  <= (state_d == StWb) || (state_d == StInit);
            wr_init_q    <= (state_d == StInit);
            dly_strb_q   <= (state_d == StWb);
            busy_q       <= (state_d != StIdle);
            init_done_q  <= init_done_d;
            frame_done_q <= (state_q == StWb) && (ch_q == LAST_CH);
            overrun_q    <= bus.frame_sync && (state_q != StIdle);
        end
    end

    assign bus.ch_addr    = ch_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.ld_strb    = ld_strb_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.wr_init    = wr_init_q;
    assign bus.dly_strb   = dly_strb_q;
    assign bus.busy       = busy_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;

`ifdef QSFA_SCHED_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Clear takes priority over a coincident overrun pulse.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (bus.ovr_clr) begin
            ovr_cnt_d = '0;
        end else if (overrun_q && ovr_cnt_q != 8'hff) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign bus.ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_qsfa_chan_sched.sv
// Directed bench for qsfa_chan_sched with NUM_CH=4, CALC_CYCLES=4.
// Overrun counter checks are built only with QSFA_SCHED_OVERRUN_CNT_EN.
module tb_qsfa_chan_sched;
    import qsfa_chan_sched_pkg::*;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned CH_W        = 2;
    localparam int unsigned CALC_CYCLES = 4;
    localparam int          PER         = QSFA_CH_OVERHEAD + CALC_CYCLES;
    localparam int          SWEEP       = NUM_CH * PER;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    qsfa_chan_sched_if #(.CH_W(CH_W)) bus ();

    qsfa_chan_sched #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .CALC_CYCLES(CALC_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_ch_addr", int'(bus.ch_addr), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_init_done", int'(bus.init_done), 0);
        check("rst_rd_en", int'(bus.mem_rd_en), 0);
        check("rst_ld_strb", int'(bus.ld_strb), 0);
        check("rst_wr_en", int'(bus.mem_wr_en), 0);
        check("rst_wr_init", int'(bus.wr_init), 0);
        check("rst_dly_strb", int'(bus.dly_strb), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_overrun", int'(bus.overrun), 0);
    endtask

    // Releases reset at a falling edge and walks the init sweep; fs injects frame_sync mid-INIT.
    task automatic init_seq(input bit fs);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            check("init_wr_en", int'(bus.mem_wr_en), 1);
            check("init_wr_init", int'(bus.wr_init), 1);
            check("init_ch_addr", int'(bus.ch_addr), i);
            check("init_dly_strb", int'(bus.dly_strb), 0);
            check("init_rd_en", int'(bus.mem_rd_en), 0);
            check("init_busy", int'(bus.busy), 1);
            check("init_done_lo", int'(bus.init_done), 0);
            check("init_overrun", int'(bus.overrun), int'(fs && i == 2));
            bus.frame_sync = fs && (i == 1);
            @(negedge clk);
        end
        bus.frame_sync = 1'b0;
        check("post_init_wr_en", int'(bus.mem_wr_en), 0);
        check("post_init_done", int'(bus.init_done), 1);
        check("post_init_busy", int'(bus.busy), 0);
        check("post_init_ch", int'(bus.ch_addr), 0);
        check("post_init_overrun", int'(bus.overrun), 0);
    endtask

    // One full sweep from IDLE; ovr_k >= 0 pulses frame_sync at that cycle of the sweep.
    task automatic sweep(input int ovr_k);
        bus.frame_sync = 1'b1;
        @(negedge clk);
        bus.frame_sync = 1'b0;
        for (int k = 0; k < SWEEP + 6; k++) begin
            int act = int'(k < SWEEP);
            int ph  = k % PER;
            check("sw_rd_en", int'(bus.mem_rd_en), int'(act == 1 && ph == 0));
            check("sw_ld_strb", int'(bus.ld_strb), int'(act == 1 && ph == 1));
            check("sw_wr_en", int'(bus.mem_wr_en), int'(act == 1 && ph == PER - 1));
            check("sw_wr_init", int'(bus.wr_init), 0);
            check("sw_dly_strb", int'(bus.dly_strb), int'(act == 1 && ph == PER - 1));
            check("sw_ch_addr", int'(bus.ch_addr), (act == 1) ? k / PER : 0);
            check("sw_busy", int'(bus.busy), act);
            check("sw_frame_done", int'(bus.frame_done), int'(k == SWEEP));
            check("sw_overrun", int'(bus.overrun), int'(ovr_k >= 0 && k == ovr_k + 1));
            check("sw_init_done", int'(bus.init_done), 1);
            bus.frame_sync = (k == ovr_k);
            @(negedge clk);
        end
        bus.frame_sync = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        bus.frame_sync = 1'b0;
`ifdef QSFA_SCHED_OVERRUN_CNT_EN
        bus.ovr_clr    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_vals();

        init_seq(1'b0);
        sweep(-1);
        // frame_sync during CALC of channel 2
        sweep(2 * PER + 3);

        // Reset mid-WB of channel 1 must clear outputs without a clock edge.
        bus.frame_sync = 1'b1;
        @(negedge clk);
        bus.frame_sync = 1'b0;
        repeat (2 * PER - 1) @(negedge clk);
        check("wb1_dly_strb", int'(bus.dly_strb), 1);
        check("wb1_ch_addr", int'(bus.ch_addr), 1);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);

        init_seq(1'b1);
        for (int i = 0; i < 5; i++) begin
            check("idle_no_rd", int'(bus.mem_rd_en), 0);
            check("idle_busy", int'(bus.busy), 0);
            @(negedge clk);
        end
        sweep(-1);

`ifdef QSFA_SCHED_OVERRUN_CNT_EN
        begin
            int n_ovr;
            check("ovr_cnt_one", int'(bus.ovr_cnt), 1);
            bus.ovr_clr = 1'b1;
            @(negedge clk);
            bus.ovr_clr = 1'b0;
            check("ovr_cnt_clr", int'(bus.ovr_cnt), 0);
            n_ovr = 0;
            bus.frame_sync = 1'b1;
            for (int i = 0; i < 350; i++) begin
                @(negedge clk);
                n_ovr += int'(bus.overrun);
            end
            bus.frame_sync = 1'b0;
            for (int i = 0; i < 2 * SWEEP; i++) begin
                @(negedge clk);
                n_ovr += int'(bus.overrun);
            end
            check("ovr_enough", int'(n_ovr >= 300), 1);
            check("ovr_cnt_sat", int'(bus.ovr_cnt), (n_ovr > 255) ? 255 : n_ovr);
            // Overrun pulse and clear in the same cycle: clear wins.
            bus.frame_sync = 1'b1;
            @(negedge clk);
            bus.frame_sync = 1'b0;
            repeat (17) @(negedge clk);
            bus.frame_sync = 1'b1;
            @(negedge clk);
            bus.frame_sync = 1'b0;
            check("ovr_pulse", int'(bus.overrun), 1);
            check("ovr_cnt_pre_clr", int'(bus.ovr_cnt), 255);
            bus.ovr_clr = 1'b1;
            @(negedge clk);
            bus.ovr_clr = 1'b0;
            check("ovr_clr_wins", int'(bus.ovr_cnt), 0);
            repeat (SWEEP) @(negedge clk);
            check("ovr_cnt_stays", int'(bus.ovr_cnt), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/qsfa_chan_sched.md
Name: qsfa_chan_sched

Overview:
Per-channel scheduler for the quantizer scale factor adaptation datapath in the multi-channel ADPCM codec. One adaptation datapath is time-shared across NUM_CH channels. On each frame_sync the block sweeps every channel through four steps: read state RAM, load, compute, write back. Each channel's write-back pulses dly_strb. After reset it also initialises every channel's stored YU/YL to their reset values.

Parameters:
NUM_CH, 32, number of channels time-sharing the datapath (2..256).
CH_W, 5, channel address width; must equal ceil(log2(NUM_CH)).
CALC_CYCLES, 4, cycles the datapath needs to settle after load (1..15).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
frame_sync  input  1  single-cycle pulse; starts a channel sweep.
ch_addr  output  CH_W  channel index driving the state RAM address.
mem_rd_en  output  1  state RAM read enable; data valid the following cycle.
ld_strb  output  1  datapath captures RAM read data (YU, YL) this cycle.
mem_wr_en  output  1  state RAM write enable.
wr_init  output  1  with mem_wr_en: write reset constants (YU=544, YL=34816) instead of datapath results.
dly_strb  output  1  one-cycle strobe to the datapath delay elements.
busy  output  1  high in any state other than IDLE.
init_done  output  1  high once the post-reset initialisation sweep has finished.
frame_done  output  1  one-cycle pulse after the last channel's write-back.
overrun  output  1  one-cycle pulse when frame_sync arrives while not in IDLE.

Behaviour:
- Reset values while reset is low:
  - State INIT; ch_addr=0; calc counter=0.
  - All strobes 0; init_done=0; busy=1.
- All outputs are registered.
- FSM states: INIT, IDLE, RD, LOAD, CALC, WB.
- INIT:
  - mem_wr_en=1 and wr_init=1 every cycle; ch_addr increments 0..NUM_CH-1.
  - After writing NUM_CH-1, go to IDLE with ch_addr=0 and init_done=1.
  - INIT lasts exactly NUM_CH cycles.
  - dly_strb stays 0 throughout INIT.
- IDLE: all strobes 0, busy=0. On frame_sync, set ch_addr=0 and go to RD.
- RD: mem_rd_en=1 for one cycle, then LOAD.
- LOAD: ld_strb=1 for one cycle, then CALC with the counter loaded to CALC_CYCLES-1.
- CALC:
  - Counter decrements each cycle; all strobes 0.
  - When the counter reaches 0, go to WB. CALC lasts exactly CALC_CYCLES cycles.
- WB:
  - mem_wr_en=1, wr_init=0, dly_strb=1, all for one cycle.
  - If ch_addr==NUM_CH-1: go to IDLE, pulse frame_done next cycle, set ch_addr=0.
  - Otherwise: increment ch_addr and go to RD.
- Per-channel period: 3+CALC_CYCLES cycles. Full sweep: NUM_CH*(3+CALC_CYCLES) cycles from the first RD.
- frame_sync in any state other than IDLE (including INIT): the sweep is not restarted and continues unaffected; overrun pulses next cycle.
- frame_sync in the same cycle the FSM is in WB of the last channel counts as an overrun; it is not queued.
- Reset asserted mid-sweep: immediately return to INIT. The full initialisation sweep reruns; any partial frame is discarded.
- ch_addr is stable for the whole RD..WB sequence of a channel. ch_addr never exceeds NUM_CH-1.

Optional Feature:
Macro QSFA_SCHED_OVERRUN_CNT_EN.
- When defined:
  - Adds output ovr_cnt [7:0], a saturating count of overrun events (stops at 255).
  - Adds input ovr_clr [1]; ovr_clr=1 synchronously clears ovr_cnt to 0.
  - If ovr_clr and overrun occur together, the clear wins.
  - ovr_cnt resets to 0.
- When not defined: the ports and counter are absent; overrun pulse behaviour is unchanged.

Decomposition:
- Shared package holds:
  - the FSM state enum (3-bit encoding);
  - constants QSFA_YU_RST=544 (13-bit) and QSFA_YL_RST=34816 (19-bit);
  - the per-channel overhead constant 3.
- One sub-module, qsfa_sched_calc_cnt: a loadable down-counter with a terminal-count flag, used for CALC.
- Channel counter and FSM stay in the top module.

Test Plan:
1. Release reset with NUM_CH=4 -> mem_wr_en=wr_init=1 for 4 cycles with ch_addr 0,1,2,3; then init_done=1, busy=0, dly_strb never high.
2. NUM_CH=4, CALC_CYCLES=4, one frame_sync in IDLE -> RD/LOAD/CALC×4/WB per channel. Exactly 4 dly_strb pulses, 7 cycles apart, at ch_addr 0..3. frame_done pulses once, 28 cycles after the first mem_rd_en.
3. frame_sync during CALC of channel 2 -> overrun pulse; sweep completes unchanged; no second sweep starts.
4. Reset low during WB of channel 1 -> outputs return to reset values asynchronously. A full 4-cycle INIT rerun follows release.
5. frame_sync during INIT -> overrun pulse; no RD until a later frame_sync in IDLE.
6. With QSFA_SCHED_OVERRUN_CNT_EN: 300 overruns -> ovr_cnt=255. ovr_clr together with an overrun -> ovr_cnt=0.
